// File: rtl/bin2bcd_pkg.sv
// ============================================================================
// Module   : bin2bcd_pkg
// Brief    : Shared state encoding and BCD constants for bin2bcd_iter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_iter_digit_adj.sv
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble digit correction: adds 3 to any digit of 5 or more.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_iter.sv
// ============================================================================
// Module   : bin2bcd_iter
// Brief    : Iterative (one bit per clock) binary-to-BCD converter with a
//            valid/ready handshake on both sides.
//            Define BIN2BCD_OVF_SAT_EN to saturate bcd to all nines and
//            report ovf when the input exceeds the digit range.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter int DIN_W  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN_W-1:0]      din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(DIN_W + 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         w_adj;
  logic [DIN_W-1:0]         r_sr;
  logic [CNT_W-1:0]         r_cnt;
  logic [ACC_W+DIN_W-1:0]   w_shl;
  logic                     w_accept;
  logic                     w_last;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_cnt == CNT_W'(1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit (r_acc[g*BCD_W +: BCD_W]),
        .adj   (w_adj[g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // Bits pushed past the top digit fall off here, which leaves din modulo 10^DIGITS.
  assign w_shl = {w_adj, r_sr} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_sr  <= din;
      r_cnt <= CNT_W'(DIN_W);
    end else if (r_state == SHIFT) begin
      {r_acc, r_sr} <= w_shl;
      r_cnt         <= r_cnt - CNT_W'(1);
    end
  end

`ifdef BIN2BCD_OVF_SAT_EN
  logic r_ovf;

  // Sticky: any 1 leaving the top digit means din >= 10^DIGITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == SHIFT) && w_adj[ACC_W-1]) begin
      r_ovf <= 1'b1;
    end
  end

  assign bcd = r_ovf ? {DIGITS{BCD_NINE}} : r_acc;
  assign ovf = r_ovf;
`else
  assign bcd = r_acc;
  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_iter.sv
// ============================================================================
// Module   : tb_bin2bcd_iter
// Brief    : Self-checking bench for bin2bcd_iter across four configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bin2bcd_iter;

`ifdef BIN2BCD_OVF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [31:0] dbus [4];
  logic [39:0] obcd [4];
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  of;

  logic [7:0]  bcd0;
  logic [7:0]  bcd1;
  logic [11:0] bcd2;
  logic [7:0]  bcd3;

  int unsigned cyc = 0;
  int          passed = 0;
  int          fails = 0;
  int          total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_iter u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .din(dbus[0][5:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .bcd(bcd0), .ovf(of[0])
  );
  bin2bcd_iter #(.DIN_W(8), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .din(dbus[1][7:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .bcd(bcd1), .ovf(of[1])
  );
  bin2bcd_iter #(.DIN_W(8), .DIGITS(3)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .din(dbus[2][7:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .bcd(bcd2), .ovf(of[2])
  );
  bin2bcd_iter #(.DIN_W(1), .DIGITS(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .din(dbus[3][0:0]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .bcd(bcd3), .ovf(of[3])
  );

  assign obcd[0] = {32'd0, bcd0};
  assign obcd[1] = {32'd0, bcd1};
  assign obcd[2] = {28'd0, bcd2};
  assign obcd[3] = {32'd0, bcd3};

  function automatic int dw(input int k);
    case (k)
      0:       return 6;
      1:       return 8;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int dg(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic longint lim_of(input int d);
    longint l = 1;
    for (int i = 0; i < d; i++) l = l * 10;
    return l;
  endfunction

  // Decimal digits from plain arithmetic; saturation or wrap beyond the range.
  function automatic logic [39:0] ref_bcd(input longint v, input int d);
    logic [39:0] r = '0;
    longint      m;
    if (SAT && v >= lim_of(d)) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
    end else begin
      m = v % lim_of(d);
      for (int i = 0; i < d; i++) begin
        r[4*i +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint v, input int d);
    return SAT && (v >= lim_of(d));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int k, input longint v);
    int n;
    dbus[k] = 32'(v);
    iv[k]   = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    n = 0;
    while (!ov[k] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency k=%0d v=%0d", k, v), 64'(n), 64'(dw(k)));
    chk($sformatf("bcd k=%0d v=%0d", k, v), {24'd0, obcd[k]}, {24'd0, ref_bcd(v, dg(k))});
    chk($sformatf("ovf k=%0d v=%0d", k, v), 64'(of[k]), 64'(ref_ovf(v, dg(k))));
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk($sformatf("ready_after k=%0d", k), 64'({ir[k], ov[k]}), 64'(2'b10));
  endtask

  initial begin
    int          n;
    int          seen;
    int unsigned t_acc;
    int unsigned t_prev;
    longint      v;

    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    for (int i = 0; i < 4; i++) dbus[i] = '0;
    #1;
    chk("reset_state", {24'd0, obcd[0], ir[0], ov[0], of[0]}, {24'd0, 40'd0, 3'b100});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed conversions and range boundaries
    run(0, 59);
    run(1, 200);
    run(2, 255);
    run(2, 0);
    run(3, 1);
    run(0, 63);
    run(1, 99);
    run(1, 100);

    // Randomized conversions on every configuration
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 4; k++) begin
        v = longint'($urandom_range(0, (1 << dw(k)) - 1));
        run(k, v);
      end
    end

    // Backpressure: result held, new request ignored while in DONE
    dbus[0] = 32'd37;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", 64'(ov[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        dbus[0] = 32'd5;
        iv[0]   = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), {55'd0, bcd0, ir[0]}, {55'd0, 8'h37, 1'b0});
      chk($sformatf("bp_valid%0d", i), 64'(ov[0]), 64'd1);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_idle%0d", i), 64'({ir[0], ov[0]}), 64'(2'b10));
      @(posedge clk); #1;
    end

    // Reset in mid-conversion discards the request
    dbus[0] = 32'd47;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_reset", {24'd0, obcd[0], ir[0], ov[0], of[0]}, {24'd0, 40'd0, 3'b100});
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov[0]) seen++;
      @(posedge clk); #1;
    end
    chk("no_valid_after_reset", 64'(seen), 64'd0);
    run(0, 12);

    // Back-to-back with in_valid and out_ready held high, all 64 inputs
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    t_prev  = 0;
    for (int d = 0; d < 64; d++) begin
      dbus[0] = 32'(d);
      n = 0;
      while (!ir[0] && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      t_acc = cyc;
      if (d > 0) chk($sformatf("b2b_period d=%0d", d), 64'(t_acc - t_prev), 64'd8);
      t_prev = t_acc;
      n = 0;
      while (!ov[0] && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("b2b_bcd d=%0d", d), {24'd0, obcd[0]}, {24'd0, ref_bcd(longint'(d), 2)});
    end
    iv[0] = 1'b0;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
